// File: rtl/wb_stage.sv
// RV32I writeback stage: picks the result source, waits for and extends load data,
// drives the register-file write port and counts retired instructions.
module wb_stage #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int NUM_REGISTER = 32,
  localparam int AW           = $clog2(NUM_REGISTER)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [AW-1:0]         rd_addr_i,
  input  logic                  rd_we_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic [2:0]            funct3_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  we_o,
  output logic [AW-1:0]         rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  load_err_o,
  output logic [63:0]           instret_o,
  output logic                  dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid_i && ready_o;
  // valid_i needs no hold requirement while ready_o is low.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT_LOAD = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_we;
  logic                  r_load_err;
  logic [AW-1:0]         r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd;
  logic [63:0]           r_instret;
  logic [AW-1:0]         r_ld_addr;
  logic                  r_ld_we;
  logic [2:0]            r_ld_f3;
  logic [1:0]            r_ld_off;

  logic                  w_accept;
  logic                  w_is_load;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_load_bad;
  logic [DATA_WIDTH-1:0] w_src;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign ready_o     = (r_state == S_IDLE) && !rst_i;
  assign w_accept    = valid_i && ready_o;
  assign w_is_load   = (wb_sel_i == 2'b01);
  assign w_illegal   = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
  assign w_misaligned = (((funct3_i == 3'b001) || (funct3_i == 3'b101)) && alu_result_i[0]) ||
                        ((funct3_i == 3'b010) && (alu_result_i[1:0] != 2'b00));
  assign w_load_bad  = w_is_load && (w_illegal || w_misaligned);
  assign w_src       = (wb_sel_i == 2'b10) ? pc_plus4_i : alu_result_i;
  assign w_shifted   = dmem_rdata_i >> {r_ld_off, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_ld_f3)
      3'b000:  w_load_data = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
      3'b101:  w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept && w_is_load && !w_load_bad) w_state_next = S_WAIT_LOAD;
      S_WAIT_LOAD: if (dmem_rvalid_i) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Result registers: write/err strobes default low every cycle, data holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_load_err <= 1'b0;
      r_rd_addr  <= '0;
      r_rd       <= '0;
      r_instret  <= '0;
      r_ld_addr  <= '0;
      r_ld_we    <= 1'b0;
      r_ld_f3    <= '0;
      r_ld_off   <= '0;
    end else begin
      r_we       <= 1'b0;
      r_load_err <= 1'b0;
      if (r_state == S_IDLE && w_accept) begin
        if (!w_is_load) begin
          r_we      <= rd_we_i && (rd_addr_i != '0);
          r_rd_addr <= rd_addr_i;
          r_rd      <= w_src;
          r_instret <= r_instret + 64'd1;
        end else if (w_load_bad) begin
          r_load_err <= 1'b1;
        end else begin
          r_ld_addr <= rd_addr_i;
          r_ld_we   <= rd_we_i;
          r_ld_f3   <= funct3_i;
          r_ld_off  <= alu_result_i[1:0];
        end
      end else if (r_state == S_WAIT_LOAD && dmem_rvalid_i) begin
        r_we      <= r_ld_we && (r_ld_addr != '0);
        r_rd_addr <= r_ld_addr;
        r_rd      <= w_load_data;
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  assign we_o        = r_we;
  assign load_err_o  = r_load_err;
  assign rd_addr_o   = r_rd_addr;
  assign rd_o        = r_rd;
  assign instret_o   = r_instret;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized scoreboard bench for wb_stage: driver pushes expected register-file
// events, a negedge monitor pops and compares whatever the stage presents.
module tb_wb_stage;

  localparam int W = 2 + 5 + 32 + 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  rd_addr_i = '0;
  logic        rd_we_i = 1'b0;
  logic [1:0]  wb_sel_i = '0;
  logic [31:0] alu_result_i = '0;
  logic [31:0] pc_plus4_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_o;
  logic        load_err_o;
  logic [63:0] instret_o;
  logic        dbg_state_o;

  wb_stage #(.DATA_WIDTH(32), .NUM_REGISTER(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i), .wb_sel_i(wb_sel_i),
    .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i), .funct3_i(funct3_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .we_o(we_o), .rd_addr_o(rd_addr_o), .rd_o(rd_o), .load_err_o(load_err_o),
    .instret_o(instret_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  longint unsigned instret_m = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load model: byte/half/word extraction with plain arithmetic.
  function automatic int load_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] word);
    longint unsigned v;
    longint unsigned b;
    longint unsigned h;
    v = word;
    v = v / (64'd1 << (8 * off));
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return 32'(v);
    endcase
  endfunction

  // Monitor: any write or error pulse must match the oldest expected event.
  always @(negedge clk_i) begin
    if (!rst_i && (we_o || load_err_o)) begin
      logic [W-1:0] e;
      chk("we_err_exclusive", {63'd0, we_o && load_err_o}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {62'd0, load_err_o, we_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", {62'd0, load_err_o, we_o}, {62'd0, e[W-1 -: 2]});
        if (e[W-1 -: 2] == 2'd1) begin
          chk("rd_addr_o", {59'd0, rd_addr_o}, {59'd0, e[W-3 -: 5]});
          chk("rd_o", {32'd0, rd_o}, {32'd0, e[W-8 -: 32]});
        end
        chk("instret_o", instret_o, e[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      valid_i       = 1'b0;
      dmem_rvalid_i = 1'($urandom_range(0, 1));
      dmem_rdata_i  = $urandom;
      alu_result_i  = $urandom;
    end
  endtask

  task automatic send(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3,
                      input logic [31:0] rdata, input int delay);
    int sz;
    @(negedge clk_i);
    chk("ready_before_accept", {63'd0, ready_o}, 64'd1);
    valid_i = 1'b1; rd_addr_i = rd; rd_we_i = we; wb_sel_i = sel;
    alu_result_i = alu; pc_plus4_i = pc; funct3_i = f3;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
    sz = load_size(f3);
    if (sel != 2'b01) begin
      instret_m++;
      if (we && rd != 0) exp_q.push_back({2'd1, rd, (sel == 2'b10) ? pc : alu, 64'(instret_m)});
      @(posedge clk_i);
    end else if (sz == 0 || (alu % sz) != 0) begin
      exp_q.push_back({2'd2, 5'd0, 32'd0, 64'(instret_m)});
      @(posedge clk_i);
    end else begin
      instret_m++;
      if (we && rd != 0) exp_q.push_back({2'd1, rd, ref_load(f3, int'(alu % 4), rdata), 64'(instret_m)});
      @(posedge clk_i);
      for (int k = 1; k < delay; k++) begin
        @(negedge clk_i);
        valid_i = 1'($urandom_range(0, 1));
        alu_result_i = $urandom;
        chk("ready_low_wait", {63'd0, ready_o}, 64'd0);
      end
      @(negedge clk_i);
      chk("ready_low_wait", {63'd0, ready_o}, 64'd0);
      valid_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
      @(posedge clk_i);
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      chk("ready_after_load", {63'd0, ready_o}, 64'd1);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_we", {63'd0, we_o}, 64'd0);
    chk("rst_err", {63'd0, load_err_o}, 64'd0);
    chk("rst_rd_addr", {59'd0, rd_addr_o}, 64'd0);
    chk("rst_rd", {32'd0, rd_o}, 64'd0);
    chk("rst_instret", instret_o, 64'd0);
    chk("rst_state", {63'd0, dbg_state_o}, 64'd0);
    chk("rst_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    instret_m = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_dut();
    send(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 3'd0, 32'h0, 1);
    idle(1);
    send(5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h0, 3'd0, 32'h0, 1);
    send(5'd1, 1'b1, 2'b10, 32'h5555_0000, 32'h0000_0104, 3'd0, 32'h0, 1);
    idle(1);
    send(5'd7, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'd0, 32'h80FF_FFFF, 3);
    send(5'd8, 1'b1, 2'b01, 32'h0000_1003, 32'h0, 3'd4, 32'h80FF_FFFF, 3);
    send(5'd9, 1'b1, 2'b01, 32'h0000_2002, 32'h0, 3'd1, 32'h8001_0000, 1);
    send(5'd10, 1'b1, 2'b01, 32'h0000_2002, 32'h0, 3'd5, 32'h8001_0000, 2);
    send(5'd11, 1'b1, 2'b01, 32'h0000_3001, 32'h0, 3'd2, 32'h0, 1);
    send(5'd12, 1'b1, 2'b01, 32'h0000_3000, 32'h0, 3'd3, 32'h0, 1);
    send(5'd13, 1'b1, 2'b01, 32'h0000_3000, 32'h0, 3'd2, 32'hCAFE_F00D, 1);
    idle(2);
    for (int i = 0; i < 4; i++)
      send(5'(20 + i), 1'b1, 2'b00, $urandom, 32'h0, 3'd0, 32'h0, 1);
    idle(2);
    chk("instret_after_directed", instret_o, 64'(instret_m));

    for (int i = 0; i < 300; i++) begin
      logic [1:0] sel;
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) sel = 2'b01;
      send(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), sel, $urandom, $urandom,
           3'($urandom_range(0, 7)), $urandom, $urandom_range(1, 4));
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk("instret_after_random", instret_o, 64'(instret_m));

    // Reset in the middle of a load; a late rvalid must be ignored.
    @(negedge clk_i);
    valid_i = 1'b1; rd_addr_i = 5'd3; rd_we_i = 1'b1; wb_sel_i = 2'b01;
    alu_result_i = 32'h0000_4000; funct3_i = 3'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("state_wait_load", {63'd0, dbg_state_o}, 64'd1);
    reset_dut();
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_2222;
    @(posedge clk_i);
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("post_rst_we", {63'd0, we_o}, 64'd0);
    chk("post_rst_instret", instret_o, 64'd0);
    chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
    send(5'd4, 1'b1, 2'b00, 32'hA5A5_5A5A, 32'h0, 3'd0, 32'h0, 1);
    idle(3);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_instret", instret_o, 64'(instret_m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I pipeline, sitting directly upstream of `register_file` and driving its write port (`we_i`, `rd_addr_i`, `rd_i`). It accepts retiring instructions from the memory stage over a valid/ready handshake. It selects the result source and waits for data-memory read data on loads, then aligns and sign-extends it. It commits at most one register write per cycle and keeps a 64-bit retired-instruction counter.

## Interface
- `DATA_WIDTH`, 32, datapath width (from `pkg_config`)
- `NUM_REGISTER`, 32, register count; address width is `$clog2(NUM_REGISTER)` (AW)
- `clk_i` in 1: clock, all state on rising edge
- `rst_i` in 1: reset, asynchronous, active-high
- `valid_i` in 1: memory stage presents an instruction
- `ready_o` out 1: stage can accept; handshake completes on an edge where `valid_i && ready_o`
- `rd_addr_i` in AW: destination register
- `rd_we_i` in 1: instruction writes a register
- `wb_sel_i` in 2: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved (handled as ALU)
- `alu_result_i` in DATA_WIDTH: ALU result, also the load address
- `pc_plus4_i` in DATA_WIDTH: link value for JAL/JALR
- `funct3_i` in 3: load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- `dmem_rvalid_i` in 1: data memory read data valid
- `dmem_rdata_i` in DATA_WIDTH: aligned 32-bit word containing the load data
- `we_o` out 1: register-file write enable
- `rd_addr_o` out AW: register-file write address
- `rd_o` out DATA_WIDTH: register-file write data
- `load_err_o` out 1: one-cycle pulse for a misaligned or illegal load
- `instret_o` out 64: retired-instruction count

## Operation
- FSM with 2 states:
  - IDLE: `ready_o`=1.
  - WAIT_LOAD: `ready_o`=0. Latched rd_addr, rd_we, funct3 and address bits [1:0] are held.
- Accept in IDLE, non-load: register `we_o` = `rd_we_i && rd_addr_i != 0`, `rd_addr_o` = `rd_addr_i`, `rd_o` = selected source. Increment `instret_o`. Stay in IDLE.
- Accept in IDLE, legal aligned load: go to WAIT_LOAD. `we_o` is cleared for the next cycle.
- WAIT_LOAD with `dmem_rvalid_i`=1:
  - Shift `dmem_rdata_i` right by 8*addr[1:0].
  - LB/LH: sign-extend from bit 7/15. LBU/LHU: zero-extend.
  - Register the write using the same x0/rd_we gating as non-loads.
  - Increment `instret_o` and return to IDLE.
- WAIT_LOAD with `dmem_rvalid_i`=0: hold state; `we_o`=0.
- Misaligned load: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0. Illegal load: funct3 = 011, 110 or 111. For either:
  - Detected at acceptance; the stage stays in IDLE.
  - `load_err_o`=1 for one cycle, `we_o`=0.
  - `instret_o` is not incremented; the memory stage has issued no request.
- `dmem_rvalid_i` in IDLE is ignored.
- Writes to x0 are suppressed (`we_o`=0), but the instruction still counts as retired.
- With no accept and no load completion in a cycle, `we_o` and `load_err_o` return to 0. `rd_addr_o`/`rd_o` hold their last values.
- `instret_o` wraps from 2^64-1 to 0.

## Timing
- Reset (asynchronous assert, synchronous-to-clock deassert by the system):
  - State goes to IDLE.
  - `we_o`, `load_err_o`, `rd_addr_o`, `rd_o` and `instret_o` are all 0.
  - `ready_o`=0 while `rst_i` is high.
- Non-load latency: accept at edge N, then `we_o`=1 during cycle N..N+1. The register file writes at edge N+1.
- Back-to-back non-loads are accepted every cycle, with `we_o` continuously high.
- Load latency: accept at edge N. The earliest `dmem_rvalid_i` is sampled at edge N+1, giving `we_o` high in the cycle after the rvalid edge. Minimum is 2 cycles from accept to write.
- `ready_o` is low from the accept edge of a load until the edge sampling `dmem_rvalid_i`. It is high again in the same cycle `we_o` is high for that load.
- Reset mid-load abandons the load. An `rvalid` arriving after reset is ignored (IDLE).
- `load_err_o` and `we_o` are never high in the same cycle.

## Test plan
- Reset then ALU op: rd_addr=5, alu_result=0x1234_5678, rd_we=1 → one cycle later `we_o`=1, `rd_addr_o`=5, `rd_o`=0x1234_5678, `instret_o`=1.
- x0 and PC+4: accept rd_addr=0 with ALU 0xDEAD_BEEF → `we_o`=0, `instret_o`=1. Then JAL: rd=1, pc_plus4=0x0000_0104 → `rd_o`=0x104.
- LB at addr[1:0]=3 with rdata=0x80FF_FFFF, rvalid 3 cycles after accept → `ready_o` low 3 cycles, then `rd_o`=0xFFFF_FF80. The same with LBU gives 0x0000_0080.
- LH at addr=2 with rdata=0x8001_0000 → `rd_o`=0xFFFF_8001. LHU gives 0x0000_8001. LW at addr=1 → `load_err_o` pulse, `we_o`=0, `instret_o` unchanged, `ready_o` stays 1.
- Back-to-back: 4 ALU ops accepted on consecutive edges → `we_o` high 4 consecutive cycles with matching data, `instret_o`=4.
- Reset asserted in WAIT_LOAD, rvalid pulsed after release → no write, `instret_o`=0, `ready_o`=1.
